// File: rtl/memoria_be.sv
// Dual-port RAM with byte-lane writes, optional registered read (write-first forwarding)
// and an optional post-reset sweep that zeroes the whole array while busy_o is high.
`timescale 1ns/1ps
module memoria_be #(
    parameter int ANCHO      = 32,
    parameter int PROF       = 8,
    parameter bit REG_RD     = 1'b1,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wren_i,
    input  logic [ANCHO/8-1:0] wrbe_i,
    input  logic [PROF-1:0]    wraddr_i,
    input  logic [ANCHO-1:0]   wrdata_i,
    input  logic               rden_i,
    input  logic [PROF-1:0]    rdaddr_i,
    output logic [ANCHO-1:0]   rddata_o,
    output logic               rdvalid_o,
    output logic               busy_o
);

    localparam int NB    = ANCHO / 8;
    localparam int DEPTH = 2 ** PROF;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;
    localparam state_t RST_STATE = CLR_ON_RST ? ST_CLEAR : ST_READY;

    state_t            state_q, state_d;
    logic [PROF-1:0]   cnt_q, cnt_d;
    logic [ANCHO-1:0]  mem [DEPTH];
    logic              busy;

    assign busy   = (state_q == ST_CLEAR);
    assign busy_o = busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    // The sweep owns the write port while busy; user writes are dropped.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wren_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wrbe_i[k]) mem[wraddr_i][8*k +: 8] <= wrdata_i[8*k +: 8];
            end
        end
    end

    // Read handshake: a read is accepted when rden_i=1 and busy_o=0; rdvalid_o marks
    // rddata_o as the result of an accepted read (next cycle registered, same cycle otherwise).
    generate
        if (REG_RD) begin : g_reg_rd
            logic [ANCHO-1:0] fwd;
            logic [ANCHO-1:0] rddata_q;
            logic             rdvalid_q;

            always_comb begin
                fwd = mem[rdaddr_i];
                if (wren_i && (wraddr_i == rdaddr_i)) begin
                    for (int k = 0; k < NB; k++) begin
                        if (wrbe_i[k]) fwd[8*k +: 8] = wrdata_i[8*k +: 8];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else if (busy) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else if (rden_i) begin
                    rddata_q  <= fwd;
                    rdvalid_q <= 1'b1;
                end else begin
                    rdvalid_q <= 1'b0;
                end
            end

            assign rddata_o  = rddata_q;
            assign rdvalid_o = rdvalid_q;
        end else begin : g_comb_rd
            assign rddata_o  = mem[rdaddr_i];
            assign rdvalid_o = rden_i & ~busy;
        end
    endgenerate

endmodule

// File: tb/tb_memoria_be.sv
// Bench for memoria_be: three instances (registered+clear, combinational+clear,
// registered+no-clear) share one stimulus stream; registered reads go through a scoreboard.
`timescale 1ns/1ps
module tb_memoria_be;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wren;
    logic [3:0]  wrbe;
    logic [7:0]  wraddr;
    logic [31:0] wrdata;
    logic        rden;
    logic [7:0]  rdaddr;

    logic [31:0] d_rddata, c_rddata, k_rddata;
    logic        d_rdvalid, c_rdvalid, k_rdvalid;
    logic        d_busy, c_busy, k_busy;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    logic        prev_rden;
    logic [31:0] last_rd;

    typedef struct {
        logic        wren;
        logic [3:0]  wrbe;
        logic [7:0]  wraddr;
        logic [31:0] wrdata;
        logic        rden;
        logic [7:0]  rdaddr;
        logic [31:0] exp_reg;
        logic [31:0] exp_comb;
    } vec_t;

    vec_t tbl[14];
    vec_t idle_v;

    memoria_be #(.ANCHO(32), .PROF(8), .REG_RD(1'b1), .CLR_ON_RST(1'b1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wren_i(wren), .wrbe_i(wrbe), .wraddr_i(wraddr),
        .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
        .rddata_o(d_rddata), .rdvalid_o(d_rdvalid), .busy_o(d_busy)
    );

    memoria_be #(.ANCHO(32), .PROF(8), .REG_RD(1'b0), .CLR_ON_RST(1'b1)) u_comb (
        .clk_i(clk_i), .rst_ni(rst_ni), .wren_i(wren), .wrbe_i(wrbe), .wraddr_i(wraddr),
        .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
        .rddata_o(c_rddata), .rdvalid_o(c_rdvalid), .busy_o(c_busy)
    );

    memoria_be #(.ANCHO(32), .PROF(8), .REG_RD(1'b1), .CLR_ON_RST(1'b0)) u_keep (
        .clk_i(clk_i), .rst_ni(rst_ni), .wren_i(wren), .wrbe_i(wrbe), .wraddr_i(wraddr),
        .wrdata_i(wrdata), .rden_i(rden), .rdaddr_i(rdaddr),
        .rddata_o(k_rddata), .rdvalid_o(k_rdvalid), .busy_o(k_busy)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // checks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // drivers
    function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [7:0] wa,
                                input logic [31:0] wd, input logic re, input logic [7:0] ra,
                                input logic [31:0] er, input logic [31:0] ec);
        vec_t v;
        v.wren = we; v.wrbe = be; v.wraddr = wa; v.wrdata = wd;
        v.rden = re; v.rdaddr = ra; v.exp_reg = er; v.exp_comb = ec;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        wren = v.wren; wrbe = v.wrbe; wraddr = v.wraddr; wrdata = v.wrdata;
        rden = v.rden; rdaddr = v.rdaddr;
    endtask

    // One READY cycle: drive after the edge, check combinational result before the next
    // edge, and retire the registered result of the previous cycle from the scoreboard.
    task automatic apply(input vec_t v);
        @(posedge clk_i);
        #1;
        drive(v);
        if (v.rden) exp_q.push_back(v.exp_reg);
        @(negedge clk_i);
        chk("reg_rdvalid", {31'd0, d_rdvalid}, {31'd0, prev_rden});
        if (d_rdvalid) begin
            if (exp_q.size() == 0) begin
                chk("reg_unexpected_read", d_rddata, 32'hxxxx_xxxx);
            end else begin
                last_rd = exp_q.pop_front();
                chk("reg_rddata", d_rddata, last_rd);
            end
        end else begin
            chk("reg_hold", d_rddata, last_rd);
        end
        if (v.rden) begin
            chk("comb_rdvalid", {31'd0, c_rdvalid}, 32'd1);
            chk("comb_rddata", c_rddata, v.exp_comb);
        end
        prev_rden = v.rden;
    endtask

    // Runs clear cycles from a negedge; optionally pokes user ports while busy.
    task automatic clear_phase(input int stop_at, input bit poke, output int n);
        bit bad;
        bad = 1'b0;
        n = 0;
        if (poke) drive(mk(1'b1, 4'hF, 8'd3, 32'hDEADBEEF, 1'b1, 8'd3, 32'h0, 32'h0));
        do begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
            if (d_busy && (d_rdvalid !== 1'b0 || c_rdvalid !== 1'b0 || d_rddata !== 32'h0))
                bad = 1'b1;
            if (n == 250) drive(idle_v);
        end while (d_busy && n < stop_at && n < 1000);
        chk("busy_gating", {31'd0, bad}, 32'd0);
    endtask

    initial begin
        int n;
        idle_v = mk(1'b0, 4'h0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0, 32'h0);
        tbl[0]  = mk(1'b1, 4'hF, 8'd5,   32'hAABBCCDD, 1'b0, 8'd0,   32'h0,        32'h0);
        tbl[1]  = mk(1'b1, 4'h5, 8'd5,   32'h11223344, 1'b0, 8'd0,   32'h0,        32'h0);
        tbl[2]  = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44);
        tbl[3]  = mk(1'b1, 4'h0, 8'd5,   32'h0,        1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44);
        tbl[4]  = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44);
        tbl[5]  = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd0,   32'h0,        32'h0);
        tbl[6]  = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd17,  32'h0,        32'h0);
        tbl[7]  = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd255, 32'h0,        32'h0);
        tbl[8]  = mk(1'b1, 4'hF, 8'd9,   32'h12345678, 1'b1, 8'd3,   32'h0,        32'h0);
        tbl[9]  = mk(1'b1, 4'hC, 8'd9,   32'hFFFF0000, 1'b1, 8'd9,   32'hFFFF5678, 32'h12345678);
        tbl[10] = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd9,   32'hFFFF5678, 32'hFFFF5678);
        tbl[11] = mk(1'b1, 4'hF, 8'd255, 32'hCAFEF00D, 1'b1, 8'd9,   32'hFFFF5678, 32'hFFFF5678);
        tbl[12] = mk(1'b1, 4'hF, 8'd0,   32'h0BADCAFE, 1'b1, 8'd255, 32'hCAFEF00D, 32'hCAFEF00D);
        tbl[13] = mk(1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 8'd0,   32'h0BADCAFE, 32'h0BADCAFE);

        // reset state
        rst_ni = 1'b0;
        drive(idle_v);
        prev_rden = 1'b0;
        last_rd   = 32'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy",     {31'd0, d_busy},    32'd1);
        chk("rst_rdvalid",  {31'd0, d_rdvalid}, 32'd0);
        chk("rst_rddata",   d_rddata,           32'h0);
        chk("rst_comb_busy",{31'd0, c_busy},    32'd1);
        chk("rst_keep_busy",{31'd0, k_busy},    32'd0);

        // full clear with user traffic that must be ignored
        rst_ni = 1'b1;
        clear_phase(1000, 1'b1, n);
        chk("clear_cycles",   n,                256);
        chk("clear_done",     {31'd0, d_busy},  32'd0);
        chk("comb_clear_done",{31'd0, c_busy},  32'd0);

        // table: byte lanes, forwarding, boundaries; the no-op write carries random data
        for (int i = 0; i < 14; i++) begin
            vec_t v;
            v = tbl[i];
            if (v.wren && v.wrbe == 4'h0) v.wrdata = $urandom_range(32'hFFFF_FFFF, 0);
            apply(v);
        end
        repeat ($urandom_range(4, 2)) apply(idle_v);

        // async reset while holding read data
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_rddata",  d_rddata,           32'h0);
        chk("async_rst_rdvalid", {31'd0, d_rdvalid}, 32'd0);
        chk("async_rst_busy",    {31'd0, d_busy},    32'd1);
        chk("async_rst_keep",    {31'd0, k_busy},    32'd0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        prev_rden = 1'b0;
        last_rd   = 32'h0;

        // contents preserved across reset without clear
        drive(mk(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd255, 32'h0, 32'h0));
        @(posedge clk_i);
        @(negedge clk_i);
        chk("keep_valid_255", {31'd0, k_rdvalid}, 32'd1);
        chk("keep_data_255",  k_rddata,           32'hCAFEF00D);
        rdaddr = 8'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("keep_data_0", k_rddata, 32'h0BADCAFE);
        drive(idle_v);

        // reset pulse around clear cycle 100, then a full-length clear
        clear_phase(98, 1'b0, n);
        chk("midclear_reached", n, 98);
        #2 rst_ni = 1'b0;
        #1;
        chk("midclear_busy",    {31'd0, d_busy},    32'd1);
        chk("midclear_rdvalid", {31'd0, d_rdvalid}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_phase(1000, 1'b0, n);
        chk("reclear_cycles", n, 256);

        apply(mk(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5, 32'h0, 32'h0));
        apply(mk(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9, 32'h0, 32'h0));
        apply(idle_v);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
